// File: rtl/issue_fu_select_table_pkg.sv
// Shared issue-stage definitions: functional-unit encodings and the default
// table geometry used by issue_fu_select_table and its counters.
package issue_fu_select_table_pkg;

  // Encoded functional-unit values carried on the issue path
  typedef enum logic [1:0] {
    FU_SIMD = 2'd0,
    FU_SALU = 2'd1,
    FU_LSU  = 2'd2,
    FU_SIMF = 2'd3
  } fu_enc_e;

  localparam int unsigned DEF_NUM_WF   = 40;
  localparam int unsigned DEF_WF_ID_W  = 6;
  localparam int unsigned DEF_NUM_FU   = 4;
  localparam int unsigned DEF_FU_ENC_W = 2;
  localparam int unsigned DEF_MAX_OUT  = 15;

  // Counter width able to hold 0..max_out inclusive
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/issue_fu_select_table_fu_outstanding_counter.sv
// Saturating outstanding-instruction counter for one functional unit.
// Optional macro FU_TABLE_ERR_CHECK_EN adds an err pulse on overflow/underflow.
module fu_outstanding_counter
  import issue_fu_select_table_pkg::*;
#(
  parameter int unsigned MAX_OUT = DEF_MAX_OUT,
  parameter int unsigned CNT_W   = cnt_width(DEF_MAX_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             full
`ifdef FU_TABLE_ERR_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: simultaneous inc/dec cancel; saturate at both ends
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign busy  = (cnt_q != '0);
  assign full  = (cnt_q == MAX_CNT);

`ifdef FU_TABLE_ERR_CHECK_EN
  assign err = (inc && full) || (dec && !busy);
`endif

endmodule

// File: rtl/issue_fu_select_table.sv
// Per-wavefront functional-unit select table with per-FU outstanding counts.
// Optional macro FU_TABLE_ERR_CHECK_EN adds the sticky fu_err protocol flag.
module issue_fu_select_table
  import issue_fu_select_table_pkg::*;
#(
  parameter int unsigned NUM_WF   = DEF_NUM_WF,
  parameter int unsigned WF_ID_W  = DEF_WF_ID_W,
  parameter int unsigned NUM_FU   = DEF_NUM_FU,
  parameter int unsigned FU_ENC_W = DEF_FU_ENC_W,
  parameter int unsigned MAX_OUT  = DEF_MAX_OUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_fu_en,
  input  logic [WF_ID_W-1:0]  wr_wfid,
  input  logic [FU_ENC_W-1:0] wr_fu_value,
  input  logic                clr_en,
  input  logic [WF_ID_W-1:0]  clr_wfid,
  input  logic [WF_ID_W-1:0]  rd_wfid,
  output logic [NUM_FU-1:0]   rd_fu,
  output logic                rd_valid,
  input  logic [NUM_FU-1:0]   fu_done,
  output logic [NUM_FU-1:0]   fu_busy,
  output logic [NUM_FU-1:0]   fu_full
`ifdef FU_TABLE_ERR_CHECK_EN
  ,
  output logic                fu_err
`endif
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUT);

  // Entry layout: bit NUM_FU is valid, bits NUM_FU-1:0 hold the one-hot FU
  logic [NUM_FU:0] tbl [NUM_WF];

  logic              wr_ok;
  logic              clr_ok;
  logic              rd_ok;
  logic [NUM_FU-1:0] dec_fu;
  logic              dec_valid;
  logic [NUM_FU-1:0] cnt_inc;
  logic [NUM_FU-1:0] cnt_busy;
  logic [NUM_FU-1:0] cnt_full;
  // Per-FU occupancy, kept visible for debug probing
  logic [CNT_W-1:0]  unused_fu_count [NUM_FU];

  assign wr_ok  = (32'(wr_wfid)  < NUM_WF);
  assign clr_ok = (32'(clr_wfid) < NUM_WF);
  assign rd_ok  = (32'(rd_wfid)  < NUM_WF);

  // Decode the FU code into one-hot; codes at or beyond NUM_FU give zero
  always_comb begin
    dec_fu = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (wr_fu_value == FU_ENC_W'(k)) begin
        dec_fu[k] = 1'b1;
      end
    end
  end

  assign dec_valid = |dec_fu;

  // Table update: retire clears valid only; a same-cycle issue overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WF; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      if (clr_en && clr_ok) begin
        tbl[clr_wfid][NUM_FU] <= 1'b0;
      end
      if (wr_fu_en && wr_ok) begin
        tbl[wr_wfid] <= {dec_valid, dec_fu};
      end
    end
  end

  // Combinational lookup of the registered table; out-of-range reads zero
  always_comb begin
    rd_fu    = '0;
    rd_valid = 1'b0;
    if (rd_ok) begin
      rd_fu    = tbl[rd_wfid][NUM_FU-1:0];
      rd_valid = tbl[rd_wfid][NUM_FU];
    end
  end

  // An ignored (out-of-range) issue must not touch the counts either
  assign cnt_inc = (wr_fu_en && wr_ok) ? dec_fu : '0;

`ifdef FU_TABLE_ERR_CHECK_EN
  logic [NUM_FU-1:0] cnt_err;
  logic              proto_err;
`endif

  for (genvar g = 0; g < NUM_FU; g++) begin : g_cnt
    fu_outstanding_counter #(
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[g]),
      .dec   (fu_done[g]),
      .count (unused_fu_count[g]),
      .busy  (cnt_busy[g]),
      .full  (cnt_full[g])
`ifdef FU_TABLE_ERR_CHECK_EN
      ,
      .err   (cnt_err[g])
`endif
    );
  end

  assign fu_busy = cnt_busy;
  assign fu_full = cnt_full;

`ifdef FU_TABLE_ERR_CHECK_EN
  assign proto_err = (|cnt_err)
                   || (wr_fu_en && !dec_valid)
                   || (wr_fu_en && !wr_ok)
                   || (clr_en && !clr_ok);

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_err <= 1'b0;
    end else if (proto_err) begin
      fu_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_fu_select_table.sv
// Directed bench for issue_fu_select_table with a scoreboard of expected
// post-edge outputs. Builds with or without FU_TABLE_ERR_CHECK_EN.
module tb_issue_fu_select_table;
  import issue_fu_select_table_pkg::*;

  localparam int unsigned NWF  = 40;
  localparam int          MAXO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_fu_en;
  logic [5:0] wr_wfid;
  logic [1:0] wr_fu_value;
  logic       clr_en;
  logic [5:0] clr_wfid;
  logic [5:0] rd_wfid;
  logic [3:0] rd_fu;
  logic       rd_valid;
  logic [3:0] fu_done;
  logic [3:0] fu_busy;
  logic [3:0] fu_full;
`ifdef FU_TABLE_ERR_CHECK_EN
  logic       fu_err;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state: table entries {valid, fu}, counts, sticky error
  logic [4:0] m_tbl [NWF];
  int         m_cnt [4];
  logic       m_err;

  typedef struct {
    string       tag;
    logic [12:0] vec;
    logic        err;
  } exp_t;

  exp_t sb[$];

  issue_fu_select_table #(
    .NUM_WF   (40),
    .WF_ID_W  (6),
    .NUM_FU   (4),
    .FU_ENC_W (2),
    .MAX_OUT  (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_fu_en    (wr_fu_en),
    .wr_wfid     (wr_wfid),
    .wr_fu_value (wr_fu_value),
    .clr_en      (clr_en),
    .clr_wfid    (clr_wfid),
    .rd_wfid     (rd_wfid),
    .rd_fu       (rd_fu),
    .rd_valid    (rd_valid),
    .fu_done     (fu_done),
    .fu_busy     (fu_busy),
    .fu_full     (fu_full)
`ifdef FU_TABLE_ERR_CHECK_EN
    ,
    .fu_err      (fu_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs_vec();
    return {rd_fu, rd_valid, fu_busy, fu_full};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] model_vec(input logic [5:0] rid);
    logic [4:0] e;
    logic [3:0] b;
    logic [3:0] f;
    e = (rid < NWF) ? m_tbl[rid] : 5'd0;
    for (int k = 0; k < 4; k++) begin
      b[k] = (m_cnt[k] != 0);
      f[k] = (m_cnt[k] == MAXO);
    end
    return {e[3:0], e[4], b, f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NWF); i++) m_tbl[i] = 5'd0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_err = 1'b0;
  endtask

  // One clock of stimulus: drive at negedge, predict, check #1 after posedge
  task automatic step(input string tag, input logic we, input logic [5:0] wid,
                      input logic [1:0] code, input logic ce, input logic [5:0] cid,
                      input logic [5:0] rid, input logic [3:0] done);
    exp_t       e;
    exp_t       got;
    logic [3:0] dfu;
    logic       wok;
    logic       cok;
    logic       inc;
    @(negedge clk);
    wr_fu_en    = we;
    wr_wfid     = wid;
    wr_fu_value = code;
    clr_en      = ce;
    clr_wfid    = cid;
    rd_wfid     = rid;
    fu_done     = done;

    dfu = 4'd0;
    if (int'(code) < 4) dfu[code] = 1'b1;
    wok = (wid < NWF);
    cok = (cid < NWF);
    if (we && !wok) m_err = 1'b1;
    if (ce && !cok) m_err = 1'b1;
    if (we && wok && dfu == 4'd0) m_err = 1'b1;
    if (ce && cok) m_tbl[cid][4] = 1'b0;
    if (we && wok) m_tbl[wid] = {|dfu, dfu};
    for (int k = 0; k < 4; k++) begin
      inc = we && wok && dfu[k];
      if (inc && m_cnt[k] == MAXO) m_err = 1'b1;
      if (done[k] && m_cnt[k] == 0) m_err = 1'b1;
      if (inc && !done[k] && m_cnt[k] < MAXO) m_cnt[k]++;
      else if (done[k] && !inc && m_cnt[k] > 0) m_cnt[k]--;
    end
    e.tag = tag;
    e.vec = model_vec(rid);
    e.err = m_err;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, obs_vec(), got.vec);
`ifdef FU_TABLE_ERR_CHECK_EN
    chk_bit({got.tag, "_err"}, fu_err, got.err);
`endif
    wr_fu_en = 1'b0;
    clr_en   = 1'b0;
    fu_done  = 4'd0;
  endtask

  // Raise reset mid-cycle and confirm outputs drop before the next edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk(tag, obs_vec(), 13'd0);
`ifdef FU_TABLE_ERR_CHECK_EN
    chk_bit({tag, "_err"}, fu_err, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    wr_fu_en    = 1'b0;
    wr_wfid     = '0;
    wr_fu_value = '0;
    clr_en      = 1'b0;
    clr_wfid    = '0;
    rd_wfid     = 6'd5;
    fu_done     = '0;
    model_reset();
    #2;
    chk("reset_outputs", obs_vec(), 13'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic issue and next-cycle lookup
    step("issue_lsu_w5", 1'b1, 6'd5, FU_LSU, 1'b0, 6'd0, 6'd5, 4'd0);
    chk("lsu_w5_direct", obs_vec(), {4'b0100, 1'b1, 4'b0100, 4'b0000});

    // Issue then retire; fu field survives the retire
    step("issue_salu_w7", 1'b1, 6'd7, FU_SALU, 1'b0, 6'd0, 6'd7, 4'd0);
    chk("salu_w7_valid", {8'd0, rd_fu, rd_valid}, {8'd0, 4'b0010, 1'b1});
    step("clr_w7", 1'b0, 6'd0, FU_SIMD, 1'b1, 6'd7, 6'd7, 4'd0);
    chk("clr_w7_direct", {8'd0, rd_fu, rd_valid}, {8'd0, 4'b0010, 1'b0});

    // Issue and retire of the same wavefront: issue wins
    step("iss_clr_w9", 1'b1, 6'd9, FU_SALU, 1'b1, 6'd9, 6'd9, 4'd0);
    chk("iss_clr_w9_direct", {8'd0, rd_fu, rd_valid}, {8'd0, 4'b0010, 1'b1});

    // Out-of-range wfids are ignored and read as zero
    step("oor_wr_clr", 1'b1, 6'd45, FU_SIMD, 1'b1, 6'd50, 6'd45, 4'd0);
    step("rd_w5_after_oor", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd5, 4'd0);

    // Asynchronous reset with non-zero counts
    do_reset("async_rst_1");

    // Fill SIMD to MAX_OUT, then one more issue saturates
    for (int i = 0; i < MAXO; i++) begin
      step("simd_fill", 1'b1, 6'(i), FU_SIMD, 1'b0, 6'd0, 6'(i), 4'd0);
    end
    chk("simd_full_direct", {9'd0, fu_full}, {9'd0, 4'b0001});
    step("simd_overflow", 1'b1, 6'd15, FU_SIMD, 1'b0, 6'd0, 6'd15, 4'd0);
`ifdef FU_TABLE_ERR_CHECK_EN
    chk_bit("overflow_err_direct", fu_err, 1'b1);
`endif
    step("simd_done_1", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd15, 4'b0001);
    chk("simd_after_done", {5'd0, fu_busy, fu_full}, {5'd0, 4'b0001, 4'b0000});
    step("done_all", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd3, 4'b1111);

    do_reset("async_rst_2");

    // SIMF: issue with simultaneous done leaves count unchanged
    step("simf_1", 1'b1, 6'd20, FU_SIMF, 1'b0, 6'd0, 6'd20, 4'd0);
    step("simf_2", 1'b1, 6'd21, FU_SIMF, 1'b0, 6'd0, 6'd21, 4'd0);
    step("simf_3", 1'b1, 6'd22, FU_SIMF, 1'b0, 6'd0, 6'd22, 4'd0);
    step("simf_iss_done", 1'b1, 6'd23, FU_SIMF, 1'b0, 6'd0, 6'd23, 4'b1000);
    step("simf_done_a", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd23, 4'b1000);
    step("simf_done_b", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd23, 4'b1000);
    chk_bit("simf_busy_at_1", fu_busy[3], 1'b1);
    step("simf_done_c", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd23, 4'b1000);
    chk_bit("simf_busy_at_0", fu_busy[3], 1'b0);
`ifdef FU_TABLE_ERR_CHECK_EN
    chk_bit("no_err_before_underflow", fu_err, 1'b0);
`endif
    step("simf_underflow", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd23, 4'b1000);
`ifdef FU_TABLE_ERR_CHECK_EN
    chk_bit("underflow_err_direct", fu_err, 1'b1);
`endif

    do_reset("async_rst_3");

    // Boundary wavefront ids: last valid entry and first invalid one
    step("issue_w39", 1'b1, 6'd39, FU_SIMF, 1'b0, 6'd0, 6'd39, 4'd0);
    chk("w39_direct", obs_vec(), {4'b1000, 1'b1, 4'b1000, 4'b0000});
    step("rd_w40", 1'b0, 6'd0, FU_SIMD, 1'b0, 6'd0, 6'd40, 4'd0);
    step("issue_w0_lsu", 1'b1, 6'd0, FU_LSU, 1'b1, 6'd39, 6'd39, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
